// File: rtl/router3of6_pkg.sv
// Shared types and the 3-of-6 symbol code used by the router's link encoder and decoder.
package router3of6_pkg;

    localparam int SYM_W = 3;
    localparam int SEG_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // Balanced code: the symbol followed by its complement always carries three ones.
    function automatic logic [SEG_W-1:0] enc3of6(input logic [SYM_W-1:0] sym);
        return {sym, ~sym};
    endfunction

endpackage

// File: rtl/six_bit_encoder.sv
// Per-segment 3-bit to 6-bit balanced encoder; mirror of the receiver's segment checker.
module six_bit_encoder
    import router3of6_pkg::*;
(
    input  logic [SYM_W-1:0] sym,
    output logic [SEG_W-1:0] code
);

    assign code = enc3of6(sym);

endmodule

// File: rtl/encoder_3of6_tx.sv
// Transmit-side 3-of-6 link encoder: latches a payload and streams one balanced
// 6-bit code word per accepted beat, segment 0 first.
module encoder_3of6_tx
    import router3of6_pkg::*;
#(
    parameter int NUM_SEG = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SYM_W*NUM_SEG-1:0] pld_in,
    input  logic                     pld_vld,
    output logic                     pld_rdy,
    output logic [SEG_W-1:0]         seg_out,
    output logic                     seg_vld,
    input  logic                     seg_rdy,
    output logic                     seg_sof,
    output logic                     seg_eof,
    output logic                     busy
);

    localparam int PLD_W = SYM_W * NUM_SEG;
    localparam int IDX_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEG - 1);

    tx_state_t        state;
    logic [PLD_W-1:0] frame;
    logic [IDX_W-1:0] seg_idx;
    logic [IDX_W-1:0] nxt_idx;
    logic [SYM_W-1:0] nxt_sym;
    logic [SEG_W-1:0] nxt_code;
    logic             is_last;
    logic             pld_acc;
    logic             seg_acc;

    assign is_last = (seg_idx == LAST_IDX);
    assign pld_rdy = (state == IDLE) | ((state == SEND) & is_last & seg_rdy);
    assign pld_acc = pld_vld & pld_rdy;
    assign seg_acc = seg_vld & seg_rdy;
    assign nxt_idx = seg_idx + IDX_W'(1);
    assign seg_vld = (state == SEND);
    assign busy    = (state == SEND);

    // Outputs are registered, so the single encoder works on the symbol of the
    // segment that becomes current at the next edge.
    always_comb begin
        nxt_sym = pld_in[SYM_W-1:0];
        if (!pld_acc) begin
            for (int k = 0; k < NUM_SEG; k++) begin
                if (nxt_idx == IDX_W'(k)) begin
                    nxt_sym = frame[k*SYM_W +: SYM_W];
                end
            end
        end
    end

    six_bit_encoder u_enc (
        .sym  (nxt_sym),
        .code (nxt_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            frame   <= '0;
            seg_idx <= '0;
            seg_out <= '0;
            seg_sof <= 1'b0;
            seg_eof <= 1'b0;
        end else if (pld_acc) begin
            state   <= SEND;
            frame   <= pld_in;
            seg_idx <= '0;
            seg_out <= nxt_code;
            seg_sof <= 1'b1;
            seg_eof <= (NUM_SEG == 1);
        end else if (seg_acc && !is_last) begin
            seg_idx <= nxt_idx;
            seg_out <= nxt_code;
            seg_sof <= 1'b0;
            seg_eof <= (nxt_idx == LAST_IDX);
        end else if (seg_acc) begin
            // Last segment taken with no payload waiting: drop back to idle.
            state   <= IDLE;
            seg_idx <= '0;
            seg_out <= '0;
            seg_sof <= 1'b0;
            seg_eof <= 1'b0;
        end
    end

endmodule

// File: doc/encoder_3of6_tx.md
# encoder_3of6_tx

Transmit-side 3-of-6 link encoder for the router's token/flit path. Accepts a 24-bit payload over a valid/ready handshake and encodes each 3-bit symbol into a balanced 6-bit code word: three ones, code = {sym, ~sym}. It then serializes the frame onto a 6-bit segment link, one code word per accepted beat, segment 0 first. The receive end reassembles the eight segments into the 48-bit frame checked by `decoder_3of6`.

## Interface
- `NUM_SEG`, 8: segments per frame; payload width = 3*NUM_SEG, frame width = 6*NUM_SEG.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pld_in` in 3*NUM_SEG: payload; sampled on accept.
- `pld_vld` in 1: payload valid.
- `pld_rdy` out 1: block can accept a payload this cycle.
- `seg_out` out 6: current code word.
- `seg_vld` out 1: `seg_out` valid.
- `seg_rdy` in 1: downstream accepts `seg_out` this cycle.
- `seg_sof` out 1: high with segment 0 of a frame.
- `seg_eof` out 1: high with segment NUM_SEG-1 of a frame.
- `busy` out 1: frame in flight (state SEND).

## Operation
- Payload accept: `pld_vld & pld_rdy` at a rising edge.
- Segment accept: `seg_vld & seg_rdy` at a rising edge.
- States:
  - IDLE: `seg_vld`=0, `pld_rdy`=1. On payload accept, latch the payload into the frame register, set `seg_idx`=0, go to SEND.
  - SEND: `seg_vld`=1.
- Segment k content: `seg_out` = {p[3k+2:3k], ~p[3k+2:3k]}. Always exactly three ones.
- SEND transitions on segment accept:
  - If `seg_idx`<NUM_SEG-1: increment `seg_idx`.
  - Else if `pld_vld`: load the new payload, set `seg_idx`=0, stay in SEND (no bubble).
  - Else: go to IDLE.
- `pld_rdy` = IDLE | (SEND & `seg_idx`==NUM_SEG-1 & `seg_rdy`). This is a combinational path from `seg_rdy`; the path is permitted and must stay glitch-free only at the edge.
- Frame flags: `seg_sof` = SEND & `seg_idx`==0. `seg_eof` = SEND & `seg_idx`==NUM_SEG-1.
- Backpressure: while `seg_vld & !seg_rdy`, `seg_out`, `seg_sof`, `seg_eof` and the frame register hold unchanged.
- `pld_in` changes while not accepted have no effect.
- `seg_idx` is $clog2(NUM_SEG) bits; it never exceeds NUM_SEG-1 and resets to 0 at each frame load, with no free-running wrap.
- Reset (any time, including mid-frame):
  - State IDLE; `seg_idx`=0; frame register=0.
  - `seg_vld`=0, `seg_out`=0, `seg_sof`=0, `seg_eof`=0, `busy`=0.
  - `pld_rdy`=1 on the first cycle after deassertion.
  - The partial frame is discarded, not resumed.

## Timing
- Payload accepted at edge N: segment 0 is valid with `seg_sof` from edge N (after N, registered outputs), i.e. the cycle after the handshake.
- With `seg_rdy` held high, a frame occupies exactly NUM_SEG cycles.
- Back-to-back frames with `pld_vld` and `seg_rdy` high sustain one segment per cycle with no idle cycle.
- All outputs except `pld_rdy` are registered.
- Simultaneous reset and handshake: reset wins.

## Structure
- Package `router3of6_pkg` contains:
  - `SYM_W`=3 and `SEG_W`=6.
  - `tx_state_t` enum {IDLE, SEND}.
  - Function `enc3of6(sym)` returning {sym, ~sym}.
- Sub-module `six_bit_encoder` (3-bit in, 6-bit out, combinational) is the natural counterpart to the receiver's per-segment checker. Instantiate one and mux its input by `seg_idx`, rather than encoding all eight segments.
- The top holds the FSM, the frame register and `seg_idx`.

## Test plan
- Payload 24'h000000 with `seg_rdy`=1 -> eight segments of 6'b000111; `seg_sof` on the first, `seg_eof` on the eighth; then `seg_vld`=0.
- Payload 24'o01234567 -> segments 111000, 110001, 101010, 100011, 011100, 010101, 001110, 000111, in that order; `popcount`=3 on every beat.
- Same payload with `seg_rdy` deasserted for 3 cycles at segment 2 -> `seg_out`=101010 held stable for 4 cycles; `pld_rdy`=0 throughout; total frame takes 11 cycles.
- Three payloads offered back-to-back with `seg_rdy`=1 -> 24 consecutive valid beats; `pld_rdy` pulses on the eof cycles only; no bubble.
- `rst_n` asserted during segment 4 -> `seg_vld`=0 and `seg_out`=0 immediately; after release, a new payload starts again at segment 0 with `seg_sof`.
- Random payloads with random `seg_rdy`, reassembled and looped into `decoder_3of6` -> `error_3of6`=0 and decoded payload equals input, for 10k frames.
